// File: rtl/signal_sequencer.sv
// Signal phase sequencer: turns a one-hot arbiter grant into a timed
// green / yellow / all-red phase with walk and emergency preemption.
module signal_sequencer #(
  parameter int MIN_GREEN    = 10,
  parameter int EXT_PER_DENS = 5,
  parameter int MAX_GREEN    = 30,
  parameter int YELLOW       = 3,
  parameter int ALL_RED      = 2,
  parameter int WALK         = 8,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       grant_N,
  input  logic       grant_E,
  input  logic       grant_S,
  input  logic       grant_W,
  input  logic [1:0] dens_N,
  input  logic [1:0] dens_E,
  input  logic [1:0] dens_S,
  input  logic [1:0] dens_W,
  input  logic       ped_N,
  input  logic       ped_E,
  input  logic       ped_S,
  input  logic       ped_W,
  input  logic       emergency_N,
  input  logic       emergency_E,
  input  logic       emergency_S,
  input  logic       emergency_W,
  output logic [1:0] light_N,
  output logic [1:0] light_E,
  output logic [1:0] light_S,
  output logic [1:0] light_W,
  output logic       walk_N,
  output logic       walk_E,
  output logic       walk_S,
  output logic       walk_W,
  output logic       phase_done,
  output logic       grant_err,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_ALL_RED = 2'd0;
  localparam logic [1:0] S_SELECT  = 2'd1;
  localparam logic [1:0] S_GREEN   = 2'd2;
  localparam logic [1:0] S_YELLOW  = 2'd3;

  localparam int GW = CNT_W + 2;
  localparam logic [CNT_W-1:0] ALL_RED_LAST = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] WALK_LEN     = CNT_W'(WALK);
  localparam logic [CNT_W:0]   MIN_G        = (CNT_W+1)'(MIN_GREEN);
  localparam logic [GW-1:0]    MAX_G        = GW'(MAX_GREEN);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_timer;
  logic [1:0]       r_dir;
  logic [CNT_W-1:0] r_glen;
  logic             r_ped_l;

  logic [3:0]       w_grant;
  logic [3:0]       w_ped;
  logic [3:0]       w_emerg;
  logic [3:0][1:0]  w_dens;
  logic             w_one_hot;
  logic             w_multi;
  logic [1:0]       w_sel_dir;
  logic [GW-1:0]    w_glen_raw;
  logic [CNT_W-1:0] w_glen_next;
  logic             w_em_other;
  logic             w_min_done;
  logic             w_green_end;
  logic [3:0][1:0]  w_light;
  logic [3:0]       w_walk;

  assign w_grant = {grant_W, grant_S, grant_E, grant_N};
  assign w_ped   = {ped_W, ped_S, ped_E, ped_N};
  assign w_emerg = {emergency_W, emergency_S, emergency_E, emergency_N};
  assign w_dens  = {dens_W, dens_S, dens_E, dens_N};

  // x & (x-1) clears the lowest set bit: nonzero means two or more grants.
  assign w_multi   = (w_grant & (w_grant - 4'd1)) != 4'd0;
  assign w_one_hot = (w_grant != 4'd0) && !w_multi;

  always_comb begin
    w_sel_dir = 2'd0;
    case (w_grant)
      4'b0010: w_sel_dir = 2'd1;
      4'b0100: w_sel_dir = 2'd2;
      4'b1000: w_sel_dir = 2'd3;
      default: w_sel_dir = 2'd0;
    endcase
  end

  assign w_glen_raw  = GW'(MIN_GREEN) + GW'(EXT_PER_DENS) * GW'(w_dens[w_sel_dir]);
  assign w_glen_next = (w_glen_raw > MAX_G) ? CNT_W'(MAX_G) : CNT_W'(w_glen_raw);

  assign w_em_other  = (w_emerg & ~(4'b0001 << r_dir)) != 4'd0;
  assign w_min_done  = ({1'b0, r_timer} + (CNT_W+1)'(1)) >= MIN_G;
  assign w_green_end = r_timer == (r_glen - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_ALL_RED;
      r_timer <= '0;
      r_dir   <= 2'd0;
      r_glen  <= '0;
      r_ped_l <= 1'b0;
    end else begin
      case (r_state)
        S_ALL_RED: begin
          if (r_timer == ALL_RED_LAST) begin
            r_timer <= '0;
            r_state <= S_SELECT;
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end
        S_SELECT: begin
          if (w_one_hot) begin
            r_dir   <= w_sel_dir;
            r_ped_l <= w_ped[w_sel_dir];
            r_glen  <= w_glen_next;
            r_timer <= '0;
            r_state <= S_GREEN;
          end
        end
        S_GREEN: begin
          // Preemption and normal expiry lead to the same transition.
          if (w_green_end || (w_em_other && w_min_done)) begin
            r_timer <= '0;
            r_state <= S_YELLOW;
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end
        default: begin
          if (r_timer == YELLOW_LAST) begin
            r_timer <= '0;
            r_state <= S_ALL_RED;
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    w_light = '0;
    w_walk  = '0;
    if (r_state == S_GREEN) begin
      w_light[r_dir] = 2'b10;
      w_walk[r_dir]  = r_ped_l && (r_timer < WALK_LEN) && (r_timer < r_glen);
    end else if (r_state == S_YELLOW) begin
      w_light[r_dir] = 2'b01;
    end
  end

  assign {light_W, light_S, light_E, light_N} = w_light;
  assign {walk_W, walk_S, walk_E, walk_N}     = w_walk;

  assign phase_done = (r_state == S_ALL_RED) && (r_timer == ALL_RED_LAST);
  assign grant_err  = (r_state == S_SELECT) && w_multi;
  assign busy       = r_state != S_SELECT;
  assign dbg_state  = r_state;

endmodule

// File: doc/signal_sequencer.md
Name: signal_sequencer

Overview:
- Consumes the one-hot grant vector from the intersection arbiter and turns it into a timed signal phase: green, yellow, all-red clearance.
- Green length scales with the granted approach's density. Pedestrian walk is driven when the served approach requested it.
- Emergency on another approach truncates green once minimum green has been served.
- Sits between the arbiter and the lamp/walk driver outputs. Samples a new grant once per phase.

Parameters:
- MIN_GREEN, 10: minimum green cycles.
- EXT_PER_DENS, 5: extra green cycles per density unit.
- MAX_GREEN, 30: green length clamp.
- YELLOW, 3: yellow cycles.
- ALL_RED, 2: all-red clearance cycles.
- WALK, 8: walk cycles at start of green.
- CNT_W, 8: timer width. Must hold MAX_GREEN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- grant_N/E/S/W  in  1 each  arbiter grant, expected one-hot
- dens_N/E/S/W  in  2 each  density level 0..3
- ped_N/E/S/W  in  1 each  pedestrian request
- emergency_N/E/S/W  in  1 each  emergency request
- light_N/E/S/W  out  2 each  00 red, 01 yellow, 10 green; 11 never driven
- walk_N/E/S/W  out  1 each  walk indication
- phase_done  out  1  one-cycle pulse on last all-red cycle
- grant_err  out  1  one-cycle pulse when SELECT sees more than one grant bit
- busy  out  1  high in every state except SELECT

Behaviour:
- Decided: one clock; reset is asynchronous and active-high (clk, rst).
- States: ALL_RED, SELECT, GREEN, YELLOW. Registers: state, timer[CNT_W], dir (2b), glen[CNT_W], ped_l.
- Reset, asynchronous, any state including mid-green:
  - state=ALL_RED, timer=0, dir=N, glen=0, ped_l=0.
  - All lights 00, all walk 0, phase_done=0, grant_err=0, busy=1.
- ALL_RED:
  - All lights red. timer increments each cycle.
  - On timer==ALL_RED-1: phase_done=1 that cycle, timer<=0, next SELECT.
  - Duration is exactly ALL_RED cycles.
- SELECT:
  - All lights red, busy=0. Combinational sample of the grant vector.
  - Exactly one bit set:
    - Latch dir and ped_l = ped of dir.
    - glen = min(MIN_GREEN + EXT_PER_DENS*dens_dir, MAX_GREEN), computed at CNT_W+2 bits before clamp.
    - timer<=0, next GREEN.
  - Zero bits: remain in SELECT, no pulse.
  - More than one bit: remain in SELECT, grant_err=1 for that cycle.
  - Inputs sampled only in SELECT. Later changes to dens/ped/grant do not affect the phase.
- GREEN:
  - light_dir=10, others 00. timer counts 0..glen-1.
  - walk_dir=1 while ped_l && timer < min(WALK, glen); all other walk 0.
  - Normal exit: on timer==glen-1, next YELLOW, timer<=0. Green lasts exactly glen cycles.
  - Preempt: any emergency_x with x≠dir, sampled at timer value t, with t+1 >= MIN_GREEN:
    - Next YELLOW, timer<=0. Green lasts t+1 cycles.
    - Walk deasserts with the transition.
  - Emergency on dir itself: ignored, no extension.
  - Preempt and normal expiry in the same cycle: identical result.
- YELLOW:
  - light_dir=01, others 00, walk 0.
  - YELLOW cycles, then ALL_RED with timer<=0.
- Outputs are registered from state/dir/timer, or decoded combinationally from registered state only. No combinational path from any input to light/walk.
- Never more than one light non-red. Any non-green light implies all walk 0.

Test Plan:
- Reset release, grant_N=1, dens_N=0, no ped: light_N green 10 cycles, yellow 3, all-red 2.
  - Timeline: 2 all-red cycles after reset, 1 SELECT cycle, then green.
  - phase_done pulses on final all-red cycle. busy=0 only in SELECT.
- grant_E=1, dens_E=2, ped_E=1: green 20 cycles; walk_E high for the first 8 green cycles only. dens_E=3 gives green 25.
- Parameter override EXT_PER_DENS=10, dens_W=3: green clamped to 30, not 40.
- grant_S=1, dens_S=3, emergency_N asserted at green timer 4 and held:
  - Yellow begins after green cycle 10.
  - With the emergency asserted at timer 15 instead: yellow after green cycle 16.
  - emergency_S alone: full 25 cycles.
- In SELECT, grant_N=grant_E=1: grant_err pulses each cycle, lights stay red, busy=0. Then grant_E only: E phase starts next cycle.
- rst asserted mid-yellow: lights and walk go red/0 immediately. Full reset timeline restarts after release.
